// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first, with valid/ready handshakes.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic             cell_d, cell_bo, last_bit, accept;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  // Single full-subtraction cell; returns {borrow_out, difference}.
  function automatic logic [1:0] fsub(input logic x, input logic y, input logic br);
    logic d, bo;
    d  = x ^ y ^ br;
    bo = (~x & y) | (~(x ^ y) & br);
    return {bo, d};
  endfunction

  assign {cell_bo, cell_d} = fsub(a_sr_q[0], b_sr_q[0], br_q);
  assign last_bit          = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept            = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        res_d  = {cell_d, {(WIDTH-1){1'b0}}} | (res_q >> 1);
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        br_d   = cell_bo;
        if (last_bit) begin
          // Outputs are captured separately so they stay frozen through the next operation.
          state_d = DONE;
          diff_d  = res_d;
          bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    a_sr_q <= a_sr_d;
    b_sr_q <= b_sr_d;
    res_q  <= res_d;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_q <= a_msb_d;
    b_msb_q <= b_msb_d;
`endif
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, bout, busy;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .bout(bout),
    .busy(busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  // Directed vectors with hand-computed results.
  logic [W-1:0] va   [7] = '{8'h05, 8'h00, 8'h10, 8'h80, 8'hF0, 8'h7F, 8'h00};
  logic [W-1:0] vb   [7] = '{8'h03, 8'h01, 8'h10, 8'h01, 8'h0F, 8'hFF, 8'h00};
  logic         vbin [7] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
  logic [W-1:0] vd   [7] = '{8'h02, 8'hFF, 8'hFF, 8'h7F, 8'hE1, 8'h80, 8'hFF};
  logic         vbo  [7] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic         vov  [7] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand set (caller ensures in_ready=1); edges counts the acceptance edge as 1.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       output logic got, output int edges);
    a = ia;
    b = ib;
    bin = ibin;
    in_valid = 1'b1;
    tick();
    edges = 1;
    in_valid = 1'b0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    got = out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got=%b exp=0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    logic got;
    int   edges;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], vbin[i], got, edges);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL vec%0d_out_valid got=%b exp=1", i, got); end
      if (i == 0) begin
        checks++; if (edges != 9) begin errors++; $display("FAIL vec0_latency got=%0d exp=9", edges); end
      end
      checks++; if (diff !== vd[i]) begin errors++; $display("FAIL vec%0d_diff got=%h exp=%h", i, diff, vd[i]); end
      checks++; if (bout !== vbo[i]) begin errors++; $display("FAIL vec%0d_bout got=%b exp=%b", i, bout, vbo[i]); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== vov[i]) begin errors++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, ovf, vov[i]); end
`endif
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL vec%0d_return got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic got;
    int   edges;
    out_ready = 1'b0;
    do_op(8'h37, 8'h12, 1'b0, got, edges);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b exp=1", got); end
    for (int i = 0; i < 5; i++) begin
      a = 8'hAA;
      b = 8'h11;
      bin = 1'b1;
      in_valid = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d got=%b exp=1", i, out_valid); end
      checks++; if (diff !== 8'h25) begin errors++; $display("FAIL bp_hold_diff cyc%0d got=%h exp=25", i, diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL bp_hold_bout cyc%0d got=%b exp=0", i, bout); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_shift();
    logic got;
    int   edges;
    int   spurious;
    a = 8'hFF;
    b = 8'h01;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL mid_no_out_valid got=%0d pulses exp=0", spurious); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    do_op(8'h09, 8'h04, 1'b0, got, edges);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_new_out_valid got=%b exp=1", got); end
    checks++; if (diff !== 8'h05) begin errors++; $display("FAIL mid_new_diff got=%h exp=05", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL mid_new_bout got=%b exp=0", bout); end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
